// File: rtl/host_uart_rsp_stream_enc.sv
// Host-side UART response encoder.
// Latches one response request and streams the framed response byte by byte:
//   [ID][6 x 00][payload, byte 0 first][status][optional XOR checksum]
// Output handshake: a byte moves on any cycle with tx_valid & tx_ready. While
// tx_valid is high and tx_ready is low, tx_data is held unchanged; tx_valid
// never drops until its byte has been accepted.
module host_uart_rsp_stream_enc #(
   parameter int         MAX_PAYLOAD_BYTES = 33,
   parameter bit         CHECKSUM_EN       = 1'b0,
   parameter logic [7:0] ENCRYPT_RSP_ID    = 8'h02,
   parameter logic [7:0] READ_YAW_RSP_ID   = 8'h04,
   parameter logic [7:0] RAW_RSP_ID        = 8'h06
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [15:0]                    cmd_select,
   input  logic                           suc_or_fail_status,
   input  logic [8*MAX_PAYLOAD_BYTES-1:0] input_data,
   input  logic [7:0]                     payload_len,
   output logic [7:0]                     tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   output logic                           busy,
   output logic                           done,
   output logic                           error,
   output logic [2:0]                     fsm_state
);

   localparam int IW = (MAX_PAYLOAD_BYTES > 1) ? $clog2(MAX_PAYLOAD_BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_STATUS  = 3'd3,
      S_CSUM    = 3'd4
   } state_t;

   state_t state_q, state_n;

   // cnt_q is the header byte index in S_HDR and the payload byte index in S_PAYLOAD
   logic [7:0]                              cnt_q, cnt_n;
   logic [7:0]                              len_q, len_n;
   logic [MAX_PAYLOAD_BYTES-1:0][7:0]       data_q, data_n;
   logic [7:0]                              status_q, status_n;
   logic [7:0]                              csum_q, csum_n;
   logic [7:0]                              tx_data_n;
   logic                                    tx_valid_n;
   logic                                    busy_n;
   logic                                    done_n;
   logic                                    error_n;

   logic                                    req_ok;
   logic [7:0]                              req_id;
   logic [7:0]                              req_len;
   logic                                    hs;
   logic [IW-1:0]                           next_idx;

   assign hs        = tx_valid & tx_ready;
   assign next_idx  = IW'(cnt_q + 8'd1);
   assign fsm_state = state_q;

   // Decode the incoming request: response ID, payload length and whether it is legal
   always_comb begin
      req_ok  = 1'b1;
      req_id  = 8'h00;
      req_len = 8'd0;
      case (cmd_select)
         16'h0001: begin
            req_id  = ENCRYPT_RSP_ID;
            req_len = 8'd0;
         end
         16'h0002: begin
            req_id  = READ_YAW_RSP_ID;
            req_len = 8'd4;
         end
         16'h0003: begin
            req_id  = RAW_RSP_ID;
            req_len = payload_len;
            if (int'(payload_len) > MAX_PAYLOAD_BYTES) req_ok = 1'b0;
         end
         default: req_ok = 1'b0;
      endcase
   end

   // Next-state and next-output logic; every byte change happens only on a handshake
   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q;
      len_n      = len_q;
      data_n     = data_q;
      status_n   = status_q;
      csum_n     = csum_q;
      tx_data_n  = tx_data;
      tx_valid_n = tx_valid;
      busy_n     = busy;
      done_n     = 1'b0;
      error_n    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (req_ok) begin
                  state_n    = S_HDR;
                  cnt_n      = 8'd0;
                  len_n      = req_len;
                  data_n     = input_data;
                  status_n   = suc_or_fail_status ? 8'h00 : 8'h01;
                  csum_n     = 8'h00;
                  tx_data_n  = req_id;
                  tx_valid_n = 1'b1;
                  busy_n     = 1'b1;
               end else begin
                  error_n = 1'b1;
               end
            end
         end

         S_HDR: begin
            if (hs) begin
               csum_n = csum_q ^ tx_data;
               if (cnt_q == 8'd6) begin
                  cnt_n = 8'd0;
                  if (len_q == 8'd0) begin
                     state_n   = S_STATUS;
                     tx_data_n = status_q;
                  end else begin
                     state_n   = S_PAYLOAD;
                     tx_data_n = data_q[0];
                  end
               end else begin
                  cnt_n     = cnt_q + 8'd1;
                  tx_data_n = 8'h00;
               end
            end
         end

         S_PAYLOAD: begin
            if (hs) begin
               csum_n = csum_q ^ tx_data;
               if (cnt_q == len_q - 8'd1) begin
                  state_n   = S_STATUS;
                  cnt_n     = 8'd0;
                  tx_data_n = status_q;
               end else begin
                  cnt_n     = cnt_q + 8'd1;
                  tx_data_n = data_q[next_idx];
               end
            end
         end

         S_STATUS: begin
            if (hs) begin
               csum_n = csum_q ^ tx_data;
               if (CHECKSUM_EN) begin
                  state_n   = S_CSUM;
                  tx_data_n = csum_q ^ tx_data;
               end else begin
                  state_n    = S_IDLE;
                  tx_data_n  = 8'h00;
                  tx_valid_n = 1'b0;
                  busy_n     = 1'b0;
                  done_n     = 1'b1;
               end
            end
         end

         S_CSUM: begin
            if (hs) begin
               state_n    = S_IDLE;
               csum_n     = 8'h00;
               tx_data_n  = 8'h00;
               tx_valid_n = 1'b0;
               busy_n     = 1'b0;
               done_n     = 1'b1;
            end
         end

         default: begin
            state_n    = S_IDLE;
            tx_data_n  = 8'h00;
            tx_valid_n = 1'b0;
            busy_n     = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         len_q    <= 8'd0;
         data_q   <= '0;
         status_q <= 8'h00;
         csum_q   <= 8'h00;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         len_q    <= len_n;
         data_q   <= data_n;
         status_q <= status_n;
         csum_q   <= csum_n;
         tx_data  <= tx_data_n;
         tx_valid <= tx_valid_n;
         busy     <= busy_n;
         done     <= done_n;
         error    <= error_n;
      end
   end

endmodule

// File: tb/tb_host_uart_rsp_stream_enc.sv
// Bench for host_uart_rsp_stream_enc: one instance without checksum (u0) and
// one with checksum (u1) share all inputs except start. A per-instance frame
// queue model predicts every output on every cycle.
module tb_host_uart_rsp_stream_enc;

  localparam int MAXP = 33;
  localparam int DW   = 8 * MAXP;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start0 = 1'b0, start1 = 1'b0;
  logic [15:0]   cmd_select = 16'h0;
  logic          suc_or_fail_status = 1'b0;
  logic [DW-1:0] input_data = '0;
  logic [7:0]    payload_len = 8'd0;
  logic          tx_ready = 1'b1;

  logic [7:0] txd0, txd1;
  logic       txv0, txv1, busy0, busy1, done0, done1, err0, err1;
  logic [2:0] fsm0, fsm1;

  host_uart_rsp_stream_enc #(.MAX_PAYLOAD_BYTES(MAXP), .CHECKSUM_EN(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .cmd_select(cmd_select),
    .suc_or_fail_status(suc_or_fail_status), .input_data(input_data),
    .payload_len(payload_len), .tx_data(txd0), .tx_valid(txv0), .tx_ready(tx_ready),
    .busy(busy0), .done(done0), .error(err0), .fsm_state(fsm0));

  host_uart_rsp_stream_enc #(.MAX_PAYLOAD_BYTES(MAXP), .CHECKSUM_EN(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .cmd_select(cmd_select),
    .suc_or_fail_status(suc_or_fail_status), .input_data(input_data),
    .payload_len(payload_len), .tx_data(txd1), .tx_valid(txv1), .tx_ready(tx_ready),
    .busy(busy1), .done(done1), .error(err1), .fsm_state(fsm1));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  logic [7:0] exp_q0[$], exp_q1[$];   // bytes still to be sent, per instance
  logic [7:0] got_q0[$], got_q1[$];   // bytes the DUT actually transferred
  logic       m_active[2];
  logic       m_done[2];
  logic       m_err[2];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic bit req_ok(logic [15:0] c, logic [7:0] l);
    return (c == 16'h1) || (c == 16'h2) || (c == 16'h3 && int'(l) <= MAXP);
  endfunction

  // Build the whole frame from the request fields and queue it
  task automatic push_frame(int i, logic [15:0] c, logic st, logic [DW-1:0] d, logic [7:0] l);
    logic [7:0] f[$];
    logic [7:0] x;
    int n;
    f = {};
    case (c)
      16'h1:   begin f.push_back(8'h02); n = 0; end
      16'h2:   begin f.push_back(8'h04); n = 4; end
      default: begin f.push_back(8'h06); n = int'(l); end
    endcase
    for (int k = 0; k < 6; k++) f.push_back(8'h00);
    for (int k = 0; k < n; k++) f.push_back(d[8*k +: 8]);
    f.push_back(st ? 8'h00 : 8'h01);
    if (i == 1) begin
      x = 8'h00;
      foreach (f[k]) x = x ^ f[k];
      f.push_back(x);
    end
    foreach (f[k]) begin
      if (i == 0) exp_q0.push_back(f[k]);
      else        exp_q1.push_back(f[k]);
    end
  endtask

  // Compare process: outputs after each rising edge, then advance the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] d, f;
      logic v, b, dn, er, st;
      logic [2:0] fs;
      int sz;
      d  = (i == 0) ? txd0  : txd1;
      v  = (i == 0) ? txv0  : txv1;
      b  = (i == 0) ? busy0 : busy1;
      dn = (i == 0) ? done0 : done1;
      er = (i == 0) ? err0  : err1;
      st = (i == 0) ? start0 : start1;
      fs = (i == 0) ? fsm0  : fsm1;
      if (reset) begin
        chk($sformatf("u%0d_rst_tx_valid", i), v, 0);
        chk($sformatf("u%0d_rst_tx_data", i), d, 0);
        chk($sformatf("u%0d_rst_busy", i), b, 0);
        chk($sformatf("u%0d_rst_done", i), dn, 0);
        chk($sformatf("u%0d_rst_error", i), er, 0);
        chk($sformatf("u%0d_rst_fsm", i), fs, 0);
        m_active[i] = 1'b0;
        m_done[i]   = 1'b0;
        m_err[i]    = 1'b0;
        if (i == 0) exp_q0 = {}; else exp_q1 = {};
      end else begin
        chk($sformatf("u%0d_tx_valid", i), v, m_active[i]);
        chk($sformatf("u%0d_busy", i), b, m_active[i]);
        chk($sformatf("u%0d_done", i), dn, m_done[i]);
        chk($sformatf("u%0d_error", i), er, m_err[i]);
        if (m_active[i]) begin
          f = (i == 0) ? exp_q0[0] : exp_q1[0];
          chk($sformatf("u%0d_tx_data", i), d, f);
        end
        if (v && tx_ready) begin
          if (i == 0) got_q0.push_back(d); else got_q1.push_back(d);
        end
        m_done[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (m_active[i]) begin
          if (tx_ready) begin
            if (i == 0) begin void'(exp_q0.pop_front()); sz = exp_q0.size(); end
            else        begin void'(exp_q1.pop_front()); sz = exp_q1.size(); end
            if (sz == 0) begin
              m_active[i] = 1'b0;
              m_done[i]   = 1'b1;
            end
          end
        end else if (st) begin
          if (req_ok(cmd_select, payload_len)) begin
            push_frame(i, cmd_select, suc_or_fail_status, input_data, payload_len);
            m_active[i] = 1'b1;
          end else begin
            m_err[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int k = 0; k < MAXP; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  task automatic set_start(int i, logic val);
    if (i == 0) start0 = val; else start1 = val;
  endtask

  // One-cycle start pulse; inputs are scrambled afterwards to prove they were latched
  task automatic issue(int i, logic [15:0] c, logic st, logic [DW-1:0] d, logic [7:0] l);
    @(posedge clk); #1;
    cmd_select = c; suc_or_fail_status = st; input_data = d; payload_len = l;
    set_start(i, 1'b1);
    @(posedge clk); #1;
    set_start(i, 1'b0);
    cmd_select = 16'($urandom); suc_or_fail_status = 1'($urandom);
    input_data = rand_data(); payload_len = 8'($urandom);
  endtask

  // mode 0: ready high, 1: toggle each cycle, 2: random
  task automatic wait_idle(int i, int mode);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (mode == 1) tx_ready = ~tx_ready;
      else if (mode == 2) tx_ready = ($urandom_range(0, 3) != 0);
      else tx_ready = 1'b1;
      if (((i == 0) ? busy0 : busy1) == 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now($sformatf("u%0d_wait_idle_timeout", i));
    @(posedge clk); #1;
    tx_ready = 1'b1;
  endtask

  task automatic check_log(int i, string name, logic [7:0] e[$]);
    logic [7:0] g[$];
    g = (i == 0) ? got_q0 : got_q1;
    chk({name, "_len"}, g.size(), e.size());
    for (int k = 0; k < e.size() && k < g.size(); k++)
      chk($sformatf("%s_byte%0d", name, k), g[k], e[k]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    logic [7:0] e[$];
    bit seen;
    int r;
    logic [15:0] c;
    for (int i = 0; i < 2; i++) begin m_active[i] = 0; m_done[i] = 0; m_err[i] = 0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // T1: cmd 1, success
    got_q0 = {};
    issue(0, 16'h1, 1'b1, rand_data(), 8'd7);
    wait_idle(0, 0);
    e = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_log(0, "t1", e);

    // T2: cmd 2, failure
    got_q0 = {};
    d = rand_data(); d[31:0] = 32'h11223344;
    issue(0, 16'h2, 1'b0, d, 8'd0);
    wait_idle(0, 0);
    e = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h01};
    check_log(0, "t2", e);

    // T3: same frame with tx_ready toggling
    got_q0 = {};
    issue(0, 16'h2, 1'b0, d, 8'd0);
    wait_idle(0, 1);
    check_log(0, "t3", e);

    // T4: rejected requests
    got_q0 = {};
    issue(0, 16'h00FF, 1'b1, rand_data(), 8'd2);
    wait_idle(0, 0);
    issue(0, 16'h3, 1'b1, rand_data(), 8'd34);
    wait_idle(0, 0);
    chk("t4_no_bytes", got_q0.size(), 0);

    // T5: checksum instance, cmd 3 len 2
    got_q1 = {};
    d = rand_data(); d[15:0] = 16'hA55A;
    issue(1, 16'h3, 1'b1, d, 8'd2);
    wait_idle(1, 0);
    e = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hA5, 8'h00, 8'hF9};
    check_log(1, "t5", e);

    // Boundary lengths on cmd 3: 0 and MAXP
    issue(1, 16'h3, 1'b0, rand_data(), 8'd0);
    wait_idle(1, 2);
    issue(0, 16'h3, 1'b1, rand_data(), 8'(MAXP));
    wait_idle(0, 2);

    // T6: reset after 3 bytes, then a clean T1 frame
    got_q0 = {};
    issue(0, 16'h2, 1'b0, rand_data(), 8'd0);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (got_q0.size() >= 3) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen) fail_now("t6_three_bytes_timeout");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    got_q0 = {};
    issue(0, 16'h1, 1'b1, rand_data(), 8'd0);
    wait_idle(0, 0);
    e = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_log(0, "t6", e);

    // Back-to-back: new start in the done cycle
    got_q0 = {};
    tx_ready = 1'b1;
    issue(0, 16'h1, 1'b1, rand_data(), 8'd0);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (done0) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("b2b_done_timeout");
    d = rand_data(); d[31:0] = 32'hDEADBEEF;
    cmd_select = 16'h2; suc_or_fail_status = 1'b1; input_data = d;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_idle(0, 0);
    e = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    check_log(0, "b2b", e);

    // Random traffic, including starts while busy and random backpressure
    for (int it = 0; it < 60; it++) begin
      int inst;
      inst = $urandom_range(0, 1);
      r = $urandom_range(0, 5);
      case (r)
        0:       c = 16'h1;
        1:       c = 16'h2;
        2, 3:    c = 16'h3;
        default: c = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom_range(4, 16'hFFFF));
      endcase
      tx_ready = ($urandom_range(0, 3) != 0);
      issue(inst, c, 1'($urandom), rand_data(), 8'($urandom_range(0, MAXP + 2)));
      if ($urandom_range(0, 9) < 7) wait_idle(inst, 2);
    end
    wait_idle(0, 2);
    wait_idle(1, 2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #5_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
